// File: rtl/ksa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone subtractor.
package ksa_pkg;

    // Group propagate/generate pair for one bit position.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Kogge-Stone combine: hi covers the upper span, lo the span just below it.
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One registered Kogge-Stone prefix level. Bit i combines with bit i-DIST
// when that bit exists; lower bits pass through. The original propagate
// vector and carry-in ride along so the output stage can form the sum.
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  pg_t [WIDTH-1:0]  pg_i,
    input  logic [WIDTH-1:0] p0_i,
    input  logic             c0_i,
    output pg_t [WIDTH-1:0]  pg_o,
    output logic [WIDTH-1:0] p0_o,
    output logic             c0_o
);

    pg_t [WIDTH-1:0]  pg_d;
    pg_t [WIDTH-1:0]  pg_q;
    logic [WIDTH-1:0] p0_q;
    logic             c0_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi >= DIST) begin : g_comb
                assign pg_d[gi] = pg_combine(pg_i[gi], pg_i[gi-DIST]);
            end else begin : g_pass
                assign pg_d[gi] = pg_i[gi];
            end
        end
    endgenerate

    // Level register; holds whenever the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pg_q <= '0;
            p0_q <= '0;
            c0_q <= 1'b0;
        end else if (en_i) begin
            pg_q <= pg_d;
            p0_q <= p0_i;
            c0_q <= c0_i;
        end
    end

    assign pg_o = pg_q;
    assign p0_o = p0_q;
    assign c0_o = c0_q;

endmodule

// File: rtl/ksa_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin. Stages: S0 (p/g/c0), one register per prefix level,
// then the output register. A single advance enable stalls everything.
module ksa_subtractor_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // Derived from WIDTH; kept local so it cannot drift out of step.
    localparam int LEVELS = clog2_f(WIDTH);

    logic adv;

    // Valid bit per stage: index 0 is S0, index k is prefix level k.
    logic [LEVELS:0] valid_q;

    // S0 registers.
    logic [WIDTH-1:0] s0_p_q;
    logic [WIDTH-1:0] s0_g_q;
    logic             s0_c0_q;

    // Stage-to-stage buses; element 0 is S0, element k is level k.
    pg_t [WIDTH-1:0]  pg_s [LEVELS+1];
    logic [WIDTH-1:0] p0_s [LEVELS+1];
    logic             c0_s [LEVELS+1];

    // Output stage.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff_d, diff_q;
    logic             bout_d, bout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_q;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Valid chain; an idle input cycle enters as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q <= {valid_q[LEVELS-1:0], in_valid};
        end
    end

    // S0: initial propagate/generate of a + ~b, carry-in is ~bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_p_q  <= '0;
            s0_g_q  <= '0;
            s0_c0_q <= 1'b0;
        end else if (adv) begin
            s0_p_q  <= a ^ ~b;
            s0_g_q  <= a & ~b;
            s0_c0_q <= ~bin;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_s0
            assign pg_s[0][gi].p = s0_p_q[gi];
            assign pg_s[0][gi].g = s0_g_q[gi];
        end
    endgenerate
    assign p0_s[0] = s0_p_q;
    assign c0_s[0] = s0_c0_q;

    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            ksa_prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << gi)
            ) u_level (
                .clk  (clk),
                .rst  (rst),
                .en_i (adv),
                .pg_i (pg_s[gi]),
                .p0_i (p0_s[gi]),
                .c0_i (c0_s[gi]),
                .pg_o (pg_s[gi+1]),
                .p0_o (p0_s[gi+1]),
                .c0_o (c0_s[gi+1])
            );
        end
    endgenerate

    // After the last level G/P at bit i span bits [i:0], so each carry is one AND-OR.
    // Signed overflow follows from the carries into and out of the sign bit.
    generate
        assign carry[0] = c0_s[LEVELS];
        for (gi = 0; gi < WIDTH; gi++) begin : g_carry
            assign carry[gi+1] = pg_s[LEVELS][gi].g | (pg_s[LEVELS][gi].p & c0_s[LEVELS]);
        end
    endgenerate

    assign diff_d = p0_s[LEVELS] ^ carry[WIDTH-1:0];
    assign bout_d = ~carry[WIDTH];
    assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

    // Output register; holds result steady while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= valid_q[LEVELS];
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ksa_subtractor_pipe.sv
// Scoreboard bench for ksa_subtractor_pipe (WIDTH=8): the driver pushes the
// expected result on every accepted operand set; the monitor pops and
// compares on every output transfer.
module tb_ksa_subtractor_pipe;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    always #5 clk = ~clk;

    ksa_subtractor_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    res_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   mon_cyc   = 0;
    int   mon_count = 0;
    int   first_cyc = -1;
    int   last_cyc  = -1;
    int   acc_count = 0;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        res_t r;
        int   ud, sa, sb, sd;
        ud = int'(ma) - int'(mb) - int'(mbin);
        r.diff = ud[W-1:0];
        r.bout = (ud < 0);
        sa = (int'(ma) >= 128) ? int'(ma) - 256 : int'(ma);
        sb = (int'(mb) >= 128) ? int'(mb) - 256 : int'(mb);
        sd = sa - sb - int'(mbin);
        r.ovf = (sd < -128) || (sd > 127);
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        res_t r;
        r.diff = d;
        r.bout = bo;
        r.ovf  = ov;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // One cycle of driving: inputs change at negedge, handshake decided before posedge.
    task automatic cycle_exp(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic tbin, input logic ordy, input res_t e);
        @(negedge clk);
        in_valid  = v;
        a         = ta;
        b         = tb;
        bin       = tbin;
        out_ready = ordy;
        #1;
        if (v && in_ready) begin
            exp_q.push_back(e);
            acc_count++;
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input logic ordy);
        cycle_exp(v, ta, tb, tbin, ordy, model(ta, tb, tbin));
    endtask

    task automatic rnd_cycle(input logic v, input logic ordy);
        logic [W-1:0] ra, rb;
        logic         rbin;
        ra   = W'($urandom);
        rb   = W'($urandom);
        rbin = 1'($urandom);
        cycle(v, ra, rb, rbin, ordy);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: every output transfer pops the oldest expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #2;
            mon_cyc++;
            if (!rst && out_valid && out_ready) begin
                mon_count++;
                if (first_cyc < 0) first_cyc = mon_cyc;
                last_cyc = mon_cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got diff=0x%0h bout=%0b ovf=%0b, expected no result",
                             diff, bout, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if (diff !== e.diff || bout !== e.bout || ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL result: got diff=0x%0h bout=%0b ovf=%0b, expected diff=0x%0h bout=%0b ovf=%0b",
                                 diff, bout, ovf, e.diff, e.bout, e.ovf);
                    end else begin
                        $display("result %0d: diff=0x%0h bout=%0b ovf=%0b ok", checks, diff, bout, ovf);
                    end
                end
            end
        end
    end

    initial begin
        int   lat;
        logic found;
        logic [W+1:0] snap;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_bout", int'(bout), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Latency and first directed value.
        cycle_exp(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b1, mk(8'h1E, 1'b0, 1'b0));
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            lat++;
            if (out_valid) found = 1'b1;
        end
        check("latency", lat, 5);
        drain(50);

        // Boundary values.
        cycle_exp(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, mk(8'hFF, 1'b1, 1'b0));
        cycle_exp(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b0, 1'b1));
        cycle_exp(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b0));
        cycle_exp(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1, mk(8'h80, 1'b1, 1'b1));
        drain(50);

        // Back-to-back stream of 16.
        mon_count = 0;
        first_cyc = -1;
        for (int i = 0; i < 16; i++) rnd_cycle(1'b1, 1'b1);
        drain(50);
        check("b2b_count", mon_count, 16);
        check("b2b_span", last_cyc - first_cyc, 15);

        // Stall: fill with out_ready low, then hold for 10 cycles.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            rnd_cycle(1'b1, 1'b0);
            if (out_valid) found = 1'b1;
        end
        check("stall_reach_valid", int'(out_valid), 1);
        snap = {diff, bout, ovf};
        for (int i = 0; i < 10; i++) begin
            rnd_cycle(1'b1, 1'b0);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_hold", int'({diff, bout, ovf}), int'(snap));
        end
        drain(50);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) rnd_cycle(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mon_count = 0;
        repeat (10) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_no_stale", mon_count, 0);
        cycle(1'b1, 8'h10, 8'h20, 1'b1, 1'b1);
        drain(50);
        check("rst_next_op", mon_count, 1);

        // Reset while a result is stalled at the output.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            rnd_cycle(1'b1, 1'b0);
            if (out_valid) found = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("stall_rst_out_valid", int'(out_valid), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mon_count = 0;
        repeat (10) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("stall_rst_no_stale", mon_count, 0);

        // Random handshake toggling over 10k operations.
        acc_count = 0;
        for (int n = 0; n < 60000 && acc_count < 10000; n++) begin
            rnd_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
        end
        check("random_accepted", acc_count, 10000);
        drain(200);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
